// File: rtl/fp_mul.sv
// IEEE-754 binary32 multiplier, round-to-nearest-even, subnormals flushed to zero.
// Latency: 1 cycle (combinational datapath into one output register).
// Backpressure: none; a new operand pair is accepted every cycle.
module fp_mul (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c,
    output logic        over_mul_under
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        sign;
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
    logic [47:0] prod;
    logic [23:0] mant;
    logic        guard, sticky, round_up;
    logic [24:0] mant_rnd;
    logic [22:0] frac_out;
    logic [10:0] exp_n;
    logic [10:0] exp_f;
    logic        ovf, unf;
    logic [31:0] c_nxt;
    logic        flag_nxt;

    assign sign   = a[31] ^ b[31];
    assign ea     = a[30:23];
    assign eb     = b[30:23];
    assign fa     = a[22:0];
    assign fb     = b[22:0];
    assign zero_a = (ea == 8'd0);
    assign zero_b = (eb == 8'd0);
    assign inf_a  = (ea == 8'hFF) && (fa == 23'd0);
    assign inf_b  = (eb == 8'hFF) && (fb == 23'd0);
    assign nan_a  = (ea == 8'hFF) && (fa != 23'd0);
    assign nan_b  = (eb == 8'hFF) && (fb != 23'd0);

    assign prod = {24'd0, 1'b1, fa} * {24'd0, 1'b1, fb};

    // Exponent is kept in 11-bit two's complement so underflow shows up as bit 10.
    always_comb begin
        exp_n  = {3'd0, ea} + {3'd0, eb} - 11'd127;
        mant   = prod[46:23];
        guard  = prod[22];
        sticky = |prod[21:0];
        if (prod[47]) begin
            mant   = prod[47:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp_n  = exp_n + 11'd1;
        end
    end

    assign round_up = guard & (sticky | mant[0]);
    assign mant_rnd = {1'b0, mant} + {24'd0, round_up};

    always_comb begin
        exp_f    = exp_n;
        frac_out = mant_rnd[22:0];
        if (mant_rnd[24]) begin
            frac_out = mant_rnd[23:1];
            exp_f    = exp_n + 11'd1;
        end
    end

    assign ovf = !exp_f[10] && (exp_f >= 11'd255);
    assign unf = exp_f[10] || (exp_f == 11'd0);

    always_comb begin
        c_nxt    = {sign, exp_f[7:0], frac_out};
        flag_nxt = 1'b0;
        if (nan_a || nan_b || (inf_a && zero_b) || (inf_b && zero_a)) begin
            c_nxt = QNAN;
        end else if (inf_a || inf_b) begin
            c_nxt = {sign, 8'hFF, 23'd0};
        end else if (zero_a || zero_b) begin
            c_nxt = {sign, 31'd0};
        end else if (ovf) begin
            c_nxt    = {sign, 8'hFF, 23'd0};
            flag_nxt = 1'b1;
        end else if (unf) begin
            c_nxt    = {sign, 31'd0};
            flag_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c              <= 32'd0;
            over_mul_under <= 1'b0;
        end else begin
            c              <= c_nxt;
            over_mul_under <= flag_nxt;
        end
    end

endmodule

// File: tb/tb_fp_mul.sv
// Directed-vector bench for fp_mul: hand-computed products, specials, async reset.
module tb_fp_mul;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        over_mul_under;

    int checks = 0;
    int errors = 0;

    fp_mul dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .a              (a),
        .b              (b),
        .c              (c),
        .over_mul_under (over_mul_under)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] exp_c, input logic exp_f);
        checks++;
        assert (c === exp_c) else begin
            errors++;
            $error("FAIL %s c: observed %h expected %h", tag, c, exp_c);
        end
        checks++;
        assert (over_mul_under === exp_f) else begin
            errors++;
            $error("FAIL %s flag: observed %b expected %b", tag, over_mul_under, exp_f);
        end
    endtask

    // Drive operands at a falling edge, then sample at the next falling edge,
    // i.e. exactly one rising edge later.
    task automatic step(input string tag, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] exp_c, input logic exp_f);
        a = va;
        b = vb;
        @(negedge clk);
        check(tag, exp_c, exp_f);
    endtask

    initial begin
        rst_n = 1'b0;
        a = 32'h3F80_0000;
        b = 32'h4000_0000;
        repeat (3) @(negedge clk);
        check("in_reset", 32'h0000_0000, 1'b0);

        rst_n = 1'b1;
        step("zero_x_zero", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);

        // Back-to-back normal products
        step("one_x_two",   32'h3F80_0000, 32'h4000_0000, 32'h4000_0000, 1'b0);
        step("1p5_x_1p5",   32'h3FC0_0000, 32'h3FC0_0000, 32'h4010_0000, 1'b0);
        step("m3_x_two",    32'hC040_0000, 32'h4000_0000, 32'hC0C0_0000, 1'b0);

        step("round_lsb",   32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 1'b0);
        step("round_even",  32'h3F80_0001, 32'h3F7F_FFFF, 32'h3F80_0000, 1'b0);

        step("overflow",    32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 1'b1);
        step("underflow",   32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 1'b1);
        step("underflow_n", 32'h8080_0000, 32'h0080_0000, 32'h8000_0000, 1'b1);

        step("inf_x_zero",  32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0);
        step("nan_x_one",   32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0);
        step("ninf_x_two",  32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 1'b0);
        step("subn_x_one",  32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 1'b0);
        step("neg_zero",    32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0);

        // Asynchronous reset while output is nonzero
        step("pre_reset",   32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'h0000_0000, 1'b0);
        @(negedge clk);
        check("reset_hold", 32'h0000_0000, 1'b0);
        rst_n = 1'b1;
        step("post_reset",  32'hC000_0000, 32'hC040_0000, 32'h40C0_0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
